// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the I/D shared-bus arbiter.
package mem_bus_arbiter_pkg;

  localparam int unsigned DefLenW     = 4;
  localparam int unsigned StarveCntW  = 4;
  localparam int unsigned PerfCntW    = 32;
  localparam logic [2:0]  ISideSize   = 3'b010;

  typedef enum logic [1:0] {
    StIdle,
    StGrantI,
    StGrantD
  } arb_state_t;

endpackage

// File: rtl/arb_starve_guard.sv
// Saturating count of D grants taken while I waits; raises force_igrant_o once the limit is hit.
module arb_starve_guard
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned MaxStarve = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic igrant_i,
  input  logic dgrant_i,
  input  logic ireq_valid_i,
  output logic force_igrant_o
);

  localparam logic [StarveCntW-1:0] MaxCnt = StarveCntW'(MaxStarve);

  logic [StarveCntW-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (igrant_i) begin
      cnt_d = '0;
    end else if (dgrant_i) begin
      if (!ireq_valid_i) begin
        cnt_d = '0;
      end else if (cnt_q >= MaxCnt) begin
        cnt_d = MaxCnt;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Only force I when it is actually waiting, so a lone D request never stalls.
  assign force_igrant_o = ireq_valid_i && (cnt_q >= MaxCnt);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Whole-transaction arbiter between fetch (I) and memory stage (D) for one shared bus port.
// Optional perf counters are enabled by defining MEM_ARB_PERF_EN.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned MAX_STARVE = 4,
  parameter int unsigned LEN_W      = DefLenW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ireq_valid,
  input  logic [31:0]      ireq_addr,
  input  logic [LEN_W-1:0] ireq_len,
  output logic             iresp_ready,
  output logic             iresp_last,
  output logic [31:0]      iresp_data,
  input  logic             dreq_valid,
  input  logic             dreq_is_write,
  input  logic [31:0]      dreq_addr,
  input  logic [2:0]       dreq_size,
  input  logic [3:0]       dreq_strobe,
  input  logic [31:0]      dreq_data,
  input  logic [LEN_W-1:0] dreq_len,
  output logic             dresp_ready,
  output logic             dresp_last,
  output logic [31:0]      dresp_data,
  output logic             creq_valid,
  output logic             creq_is_write,
  output logic [31:0]      creq_addr,
  output logic [2:0]       creq_size,
  output logic [3:0]       creq_strobe,
  output logic [31:0]      creq_data,
  output logic [LEN_W-1:0] creq_len,
  input  logic             cresp_ready,
  input  logic             cresp_last,
  input  logic [31:0]      cresp_data
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [PerfCntW-1:0] perf_igrant,
  output logic [PerfCntW-1:0] perf_dgrant,
  output logic [PerfCntW-1:0] perf_conflict
`endif
);

  arb_state_t state_d, state_q;
  logic       force_igrant;
  logic       igrant, dgrant;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (dreq_valid && !force_igrant) begin
          state_d = StGrantD;
        end else if (ireq_valid) begin
          state_d = StGrantI;
        end
      end
      StGrantI, StGrantD: begin
        if (cresp_ready && cresp_last) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  assign igrant = (state_q == StIdle) && (state_d == StGrantI);
  assign dgrant = (state_q == StIdle) && (state_d == StGrantD);

  arb_starve_guard #(
    .MaxStarve(MAX_STARVE)
  ) u_starve_guard (
    .clk_i         (clk),
    .reset_i       (reset),
    .igrant_i      (igrant),
    .dgrant_i      (dgrant),
    .ireq_valid_i  (ireq_valid),
    .force_igrant_o(force_igrant)
  );

  // Request side depends only on registered state, never on cresp_*.
  always_comb begin
    creq_valid    = 1'b0;
    creq_is_write = 1'b0;
    creq_addr     = '0;
    creq_size     = '0;
    creq_strobe   = '0;
    creq_data     = '0;
    creq_len      = '0;
    iresp_ready   = 1'b0;
    iresp_last    = 1'b0;
    iresp_data    = '0;
    dresp_ready   = 1'b0;
    dresp_last    = 1'b0;
    dresp_data    = '0;
    unique case (state_q)
      StGrantI: begin
        creq_valid  = ireq_valid;
        creq_addr   = ireq_addr;
        creq_size   = ISideSize;
        creq_len    = ireq_len;
        iresp_ready = cresp_ready;
        iresp_last  = cresp_last;
        iresp_data  = cresp_data;
      end
      StGrantD: begin
        creq_valid    = dreq_valid;
        creq_is_write = dreq_is_write;
        creq_addr     = dreq_addr;
        creq_size     = dreq_size;
        creq_strobe   = dreq_strobe;
        creq_data     = dreq_data;
        creq_len      = dreq_len;
        dresp_ready   = cresp_ready;
        dresp_last    = cresp_last;
        dresp_data    = cresp_data;
      end
      default: ;
    endcase
  end

`ifdef MEM_ARB_PERF_EN
  logic [PerfCntW-1:0] perf_igrant_q, perf_dgrant_q, perf_conflict_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_igrant_q   <= '0;
      perf_dgrant_q   <= '0;
      perf_conflict_q <= '0;
    end else begin
      if (igrant) perf_igrant_q <= perf_igrant_q + 1'b1;
      if (dgrant) perf_dgrant_q <= perf_dgrant_q + 1'b1;
      if (state_q == StIdle && ireq_valid && dreq_valid) begin
        perf_conflict_q <= perf_conflict_q + 1'b1;
      end
    end
  end

  assign perf_igrant   = perf_igrant_q;
  assign perf_dgrant   = perf_dgrant_q;
  assign perf_conflict = perf_conflict_q;
`endif

  // A granted requester must hold valid until its last beat is returned.
  a_ivalid_held: assert property (@(posedge clk) disable iff (reset)
    (state_q == StGrantI) |-> ireq_valid);
  a_dvalid_held: assert property (@(posedge clk) disable iff (reset)
    (state_q == StGrantD) |-> dreq_valid);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: directed vectors, monitor checks grants and response routing.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  localparam int unsigned LenW  = 4;
  localparam logic [31:0] IAddr = 32'h1000_0000;
  localparam logic [31:0] DAddr = 32'h2000_0000;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            ireq_valid = 1'b0;
  logic [31:0]     ireq_addr = '0;
  logic [LenW-1:0] ireq_len = '0;
  logic            iresp_ready, iresp_last;
  logic [31:0]     iresp_data;
  logic            dreq_valid = 1'b0, dreq_is_write = 1'b0;
  logic [31:0]     dreq_addr = '0;
  logic [2:0]      dreq_size = '0;
  logic [3:0]      dreq_strobe = '0;
  logic [31:0]     dreq_data = '0;
  logic [LenW-1:0] dreq_len = '0;
  logic            dresp_ready, dresp_last;
  logic [31:0]     dresp_data;
  logic            creq_valid, creq_is_write;
  logic [31:0]     creq_addr, creq_data;
  logic [2:0]      creq_size;
  logic [3:0]      creq_strobe;
  logic [LenW-1:0] creq_len;
  logic            cresp_ready = 1'b0, cresp_last = 1'b0;
  logic [31:0]     cresp_data = '0;
`ifdef MEM_ARB_PERF_EN
  logic [31:0]     perf_igrant, perf_dgrant, perf_conflict;
`endif

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .MAX_STARVE(4),
    .LEN_W     (LenW)
  ) u_dut (
    .clk          (clk),
    .reset        (reset),
    .ireq_valid   (ireq_valid),
    .ireq_addr    (ireq_addr),
    .ireq_len     (ireq_len),
    .iresp_ready  (iresp_ready),
    .iresp_last   (iresp_last),
    .iresp_data   (iresp_data),
    .dreq_valid   (dreq_valid),
    .dreq_is_write(dreq_is_write),
    .dreq_addr    (dreq_addr),
    .dreq_size    (dreq_size),
    .dreq_strobe  (dreq_strobe),
    .dreq_data    (dreq_data),
    .dreq_len     (dreq_len),
    .dresp_ready  (dresp_ready),
    .dresp_last   (dresp_last),
    .dresp_data   (dresp_data),
    .creq_valid   (creq_valid),
    .creq_is_write(creq_is_write),
    .creq_addr    (creq_addr),
    .creq_size    (creq_size),
    .creq_strobe  (creq_strobe),
    .creq_data    (creq_data),
    .creq_len     (creq_len),
    .cresp_ready  (cresp_ready),
    .cresp_last   (cresp_last),
    .cresp_data   (cresp_data)
`ifdef MEM_ARB_PERF_EN
    ,
    .perf_igrant  (perf_igrant),
    .perf_dgrant  (perf_dgrant),
    .perf_conflict(perf_conflict)
`endif
  );

  typedef struct {
    logic        is_d;
    logic        last;
    logic [31:0] data;
  } resp_t;

  typedef struct {
    logic [31:0]     addr;
    logic            wr;
    logic [2:0]      size;
    logic [3:0]      strobe;
    logic [31:0]     data;
    logic [LenW-1:0] len;
  } grant_t;

  resp_t  rq[$];
  grant_t gq[$];
  int     n_pass = 0;
  int     n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected grant is built from the bench's own stimulus fields for that side.
  task automatic push_grant(input logic is_d);
    grant_t g;
    if (is_d) begin
      g.addr = dreq_addr; g.wr = dreq_is_write; g.size = dreq_size;
      g.strobe = dreq_strobe; g.data = dreq_data; g.len = dreq_len;
    end else begin
      g.addr = ireq_addr; g.wr = 1'b0; g.size = 3'b010;
      g.strobe = 4'h0; g.data = 32'h0; g.len = ireq_len;
    end
    gq.push_back(g);
  endtask

  // Wait (bounded) for a grant, then return `beats` response beats for side is_d.
  task automatic run_txn(input logic is_d, input int beats, input logic [31:0] base,
                         output int lat);
    resp_t r;
    logic  got = 1'b0;
    lat = 0;
    for (int c = 0; c < 8 && !got; c++) begin
      tick();
      lat++;
      got = creq_valid;
    end
    check("grant_seen", got, 1'b1);
    if (got) begin
      for (int b = 0; b < beats; b++) begin
        cresp_ready = 1'b1;
        cresp_last  = (b == beats - 1);
        cresp_data  = base + b;
        r.is_d = is_d; r.last = cresp_last; r.data = cresp_data;
        rq.push_back(r);
        tick();
      end
    end
    cresp_ready = 1'b0;
    cresp_last  = 1'b0;
    cresp_data  = '0;
  endtask

  // Monitor: grant attributes on each rising creq_valid, response routing on each beat.
  logic   prev_creq_valid = 1'b0;
  grant_t mg;
  resp_t  mr;
  always @(negedge clk) begin
    if (creq_valid && !prev_creq_valid) begin
      if (gq.size() == 0) begin
        check("grant_unexpected", creq_addr, 32'hxxxx_xxxx);
      end else begin
        mg = gq.pop_front();
        check("grant_addr", creq_addr, mg.addr);
        check("grant_wr", creq_is_write, mg.wr);
        check("grant_size", creq_size, mg.size);
        check("grant_strobe", creq_strobe, mg.strobe);
        check("grant_data", creq_data, mg.data);
        check("grant_len", creq_len, mg.len);
      end
    end
    prev_creq_valid = creq_valid;
    if (iresp_ready || dresp_ready) begin
      if (rq.size() == 0) begin
        check("resp_unexpected", {iresp_ready, dresp_ready}, 2'b00);
      end else begin
        mr = rq.pop_front();
        check("resp_side_d", dresp_ready, mr.is_d);
        check("resp_side_i", iresp_ready, !mr.is_d);
        check("resp_last", mr.is_d ? dresp_last : iresp_last, mr.last);
        check("resp_data", mr.is_d ? dresp_data : iresp_data, mr.data);
        check("resp_other_quiet", mr.is_d ? {iresp_last, iresp_data} : {dresp_last, dresp_data},
              32'h0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  logic order[10];
  int   lat;

  initial begin
    // Reset state
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    check("rst_state", u_dut.state_q, StIdle);
    check("rst_cnt", u_dut.u_starve_guard.cnt_q, 0);
    check("rst_creq_valid", creq_valid, 0);
    check("rst_creq_addr", creq_addr, 0);
    check("rst_resp", {iresp_ready, dresp_ready}, 0);

    // Lone D load
    tick();
    dreq_valid = 1'b1; dreq_is_write = 1'b0; dreq_addr = 32'h8000_1000;
    dreq_size = 3'b010; dreq_strobe = 4'hF; dreq_data = 32'h0; dreq_len = 4'd0;
    push_grant(1'b1);
    @(negedge clk);
    check("lone_d_no_early_grant", creq_valid, 0);
    run_txn(1'b1, 1, 32'hDEAD_BEEF, lat);
    check("lone_d_latency", lat, 1);
    dreq_valid = 1'b0;
    check("lone_d_back_idle", u_dut.state_q, StIdle);
    check("lone_d_cnt", u_dut.u_starve_guard.cnt_q, 0);

    // Both continuously valid: D,D,D,D,I,D,D,D,D,I
    ireq_valid = 1'b1; ireq_addr = IAddr; ireq_len = 4'd0;
    dreq_valid = 1'b1; dreq_is_write = 1'b1; dreq_addr = DAddr; dreq_size = 3'b010;
    dreq_strobe = 4'hC; dreq_data = 32'hA5A5_0000; dreq_len = 4'd0;
    order = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 10; k++) push_grant(order[k]);
    for (int k = 0; k < 10; k++) begin
      run_txn(order[k], 1, 32'h100 + k, lat);
      if (k == 0) check("first_d_cnt", u_dut.u_starve_guard.cnt_q, 1);
      if (k == 3) check("sat_cnt", u_dut.u_starve_guard.cnt_q, 4);
    end
    check("after_i_cnt", u_dut.u_starve_guard.cnt_q, 0);
    ireq_valid = 1'b0; dreq_valid = 1'b0;

    // cresp in IDLE is ignored
    cresp_ready = 1'b1; cresp_last = 1'b1; cresp_data = 32'hFFFF_FFFF;
    @(negedge clk);
    check("idle_cresp_d", {dresp_ready, dresp_last}, 0);
    check("idle_cresp_i", {iresp_ready, iresp_last}, 0);
    tick();
    check("idle_cresp_state", u_dut.state_q, StIdle);
    cresp_ready = 1'b0; cresp_last = 1'b0; cresp_data = '0;

    // I burst of four beats
    ireq_valid = 1'b1; ireq_addr = 32'h1000_0040; ireq_len = 4'd3;
    push_grant(1'b0);
    run_txn(1'b0, 4, 32'h1111_0000, lat);
    ireq_valid = 1'b0;
    check("iburst_idle", u_dut.state_q, StIdle);

    // Reset during a D burst
    ireq_valid = 1'b1; ireq_addr = IAddr; ireq_len = 4'd0;
    dreq_valid = 1'b1; dreq_is_write = 1'b0; dreq_addr = 32'h2000_0080; dreq_len = 4'd3;
    dreq_strobe = 4'hF; dreq_data = 32'h0;
    push_grant(1'b1);
    tick();
    check("rstmid_granted", creq_valid, 1);
    check("rstmid_cnt_pre", u_dut.u_starve_guard.cnt_q, 1);
    cresp_ready = 1'b1; cresp_last = 1'b0; cresp_data = 32'h5555_0000;
    rq.push_back('{1'b1, 1'b0, 32'h5555_0000});
    tick();
    cresp_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0; ireq_valid = 1'b0; dreq_valid = 1'b0;
    cresp_ready = 1'b1;
    @(negedge clk);
    check("rstmid_creq_valid", creq_valid, 0);
    check("rstmid_dresp_ready", dresp_ready, 0);
    check("rstmid_state", u_dut.state_q, StIdle);
    check("rstmid_cnt", u_dut.u_starve_guard.cnt_q, 0);
    tick();
    cresp_ready = 1'b0;

    // Five conflicting transactions from a clean reset: D,D,D,D,I
    ireq_valid = 1'b1; ireq_addr = IAddr; ireq_len = 4'd0;
    dreq_valid = 1'b1; dreq_is_write = 1'b1; dreq_addr = DAddr; dreq_len = 4'd0;
    dreq_strobe = 4'h3; dreq_data = 32'h0BAD_F00D;
    order = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int k = 0; k < 5; k++) push_grant(order[k]);
    for (int k = 0; k < 5; k++) run_txn(order[k], 1, 32'h200 + k, lat);
    ireq_valid = 1'b0; dreq_valid = 1'b0;
    repeat (2) tick();
`ifdef MEM_ARB_PERF_EN
    check("perf_conflict", perf_conflict, 5);
    check("perf_igrant", perf_igrant, 1);
    check("perf_dgrant", perf_dgrant, 4);
    check("perf_sum", perf_igrant + perf_dgrant, 5);
`endif
    check("end_state", u_dut.state_q, StIdle);
    check("resp_queue_empty", rq.size(), 0);
    check("grant_queue_empty", gq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Arbitrates between instruction fetch (I side) and the memory stage's load/store requests (D side) for one shared cached-bus port toward the cache/AXI bridge.
- Grants whole transactions and routes each response beat back to the granted requester only.
- D side has priority; a starvation guard bounds how long I side can be held off.
- Sits between the pipeline's fetch/memory stages and the single external bus adapter.

Parameters:
- MAX_STARVE, 4: consecutive D grants allowed while I is waiting before I is forced through; range 1..15.
- LEN_W, 4: width of the burst-length field (beats minus one).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- ireq_valid  input  1  I request valid; held until its last beat is accepted
- ireq_addr  input  32  I address
- ireq_len  input  LEN_W  I burst beats minus one
- iresp_ready  output  1  I response beat valid
- iresp_last  output  1  I final beat
- iresp_data  output  32  I read data
- dreq_valid  input  1  D request valid; held until its last beat is accepted
- dreq_is_write  input  1  D store
- dreq_addr  input  32  D address
- dreq_size  input  3  D access size
- dreq_strobe  input  4  D byte strobes
- dreq_data  input  32  D write data for the current beat
- dreq_len  input  LEN_W  D burst beats minus one
- dresp_ready  output  1  D response beat valid
- dresp_last  output  1  D final beat
- dresp_data  output  32  D read data
- creq_valid  output  1  shared-bus request valid
- creq_is_write  output  1  shared-bus write
- creq_addr  output  32  shared-bus address
- creq_size  output  3  shared-bus size
- creq_strobe  output  4  shared-bus strobes
- creq_data  output  32  shared-bus write data
- creq_len  output  LEN_W  shared-bus burst length
- cresp_ready  input  1  shared-bus beat accepted/returned
- cresp_last  input  1  shared-bus final beat
- cresp_data  input  32  shared-bus read data

Behaviour:
- Clock and reset: all state on clk; reset is synchronous and active-high.
- Reset values: state=IDLE, starve_cnt=0; all outputs 0.
- States: IDLE, GRANT_I, GRANT_D.
- IDLE transitions:
  - dreq_valid and starve_cnt<MAX_STARVE -> GRANT_D
  - else ireq_valid -> GRANT_I
  - else stay in IDLE
  - If only ireq_valid is high, go to GRANT_I regardless of starve_cnt.
- Grant latency: grant is registered, so the first creq_valid appears 1 cycle after the request is seen in IDLE.
- Outputs in IDLE: creq_* all 0.
- Outputs in GRANT_x:
  - creq_* are combinationally driven from the granted requester's fields, with creq_valid = granted req_valid.
  - I grant drives creq_is_write=0, creq_size=3'b010, creq_strobe=0, creq_data=0.
- Response routing:
  - Granted side: resp_ready=cresp_ready, resp_last=cresp_last, resp_data=cresp_data.
  - Other side: ready, last and data all 0.
- Completion: cresp_ready && cresp_last in GRANT_x returns to IDLE on the next edge. Back-to-back transactions therefore have a 1-cycle IDLE bubble.
- Starvation counter (LEN_W-agnostic, 4 bits):
  - On entering GRANT_D while ireq_valid=1: starve_cnt+1, saturating at MAX_STARVE.
  - On entering GRANT_I: starve_cnt clears to 0.
  - On entering GRANT_D while ireq_valid=0: starve_cnt clears to 0.
- Requester deasserts valid mid-transaction: this is a protocol violation. The state is held until cresp_last; a simulation assertion flags it.
- cresp_ready in IDLE is ignored; no response is routed.
- Reset mid-transaction: IDLE and all outputs 0 from the next cycle. No pending beats are tracked.
- No combinational path from cresp_* to creq_valid.

Optional Feature:
- Macro: MEM_ARB_PERF_EN.
- Defined:
  - Adds outputs perf_igrant, perf_dgrant and perf_conflict, each 32 bits.
  - Counts I grants, D grants, and IDLE cycles where both requests are valid.
  - All three are cleared by reset and wrap at 2^32.
- Undefined: the ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package: arb_state_t enum, LEN_W default, the I-side fixed size constant, and the perf counter width.
- Sub-module arb_starve_guard: holds the saturating counter plus the force-I decision. It takes grant events and ireq_valid and outputs force_i.

Test Plan:
- Lone D load, len=0, 0x8000_1000: creq_valid rises 1 cycle after dreq_valid. A cresp_ready&last with data 0xDEADBEEF gives dresp_data=0xDEADBEEF, iresp_ready=0, then IDLE.
- Simultaneous I and D valid, starve_cnt=0: D granted first, and starve_cnt=1 after the grant.
- Both sides continuously valid, MAX_STARVE=4: grant order is D,D,D,D,I,D,D,D,D,I.
- I burst len=3: four cresp_ready beats map to four iresp_ready beats, with iresp_last only on the 4th. D sees nothing.
- Reset asserted in GRANT_D mid-burst: next cycle creq_valid=0, dresp_ready=0, state IDLE, starve_cnt=0.
- With MEM_ARB_PERF_EN and 5 conflicting IDLE cycles: perf_conflict=5, and perf_igrant+perf_dgrant equals the number of completed grants.
